// File: rtl/sync_up.sv
// ---------------------------------------------------------------------------
// sync_up
//
// Synchronous binary up counter built from WIDTH JK flip-flop stages wired
// in toggle form (J = K). Every stage shares the one clock, so all bits
// change on the same rising edge and no bit clocks another.
//
// Stage 0 toggles on every edge. Stage i toggles when all lower bits are 1,
// which is the carry into that bit. From all-ones the count wraps to zero
// on the next edge with no stall.
//
// Ports
//   clk : single clock; state changes on its rising edge only
//   rst : asynchronous, active-low reset; rst = 0 forces q to 0 at once
//   q   : current count (q[0] = LSB), driven straight from the stage flops
//
// Parameters
//   WIDTH : counter width in bits, 1..16
// ---------------------------------------------------------------------------
module sync_up #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] q
);

    // Current and next state of every JK stage.
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // J and K inputs of every stage. They are tied together, so each stage
    // either holds (0,0) or toggles (1,1).
    logic [WIDTH-1:0] j_in;
    logic [WIDTH-1:0] k_in;

    // Toggle condition per stage: the AND of all lower bits.
    logic [WIDTH-1:0] toggle_en;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_stage
            // The LSB has no lower bits, so it toggles unconditionally.
            // Higher stages AND the lower bits directly rather than chaining
            // through the previous stage's enable, which keeps every enable
            // a function of flop outputs only.
            if (gi == 0) begin : g_lsb
                assign toggle_en[gi] = 1'b1;
            end else begin : g_upper
                assign toggle_en[gi] = &cnt_q[gi-1:0];
            end

            assign j_in[gi] = toggle_en[gi];
            assign k_in[gi] = toggle_en[gi];

            // Full JK behaviour; only hold and toggle are reachable here
            // because J and K are always equal.
            always_comb begin
                cnt_d[gi] = cnt_q[gi];
                case ({j_in[gi], k_in[gi]})
                    2'b00:   cnt_d[gi] = cnt_q[gi];
                    2'b01:   cnt_d[gi] = 1'b0;
                    2'b10:   cnt_d[gi] = 1'b1;
                    2'b11:   cnt_d[gi] = ~cnt_q[gi];
                    default: cnt_d[gi] = cnt_q[gi];
                endcase
            end

            // Asynchronous active-low clear. An edge that arrives while
            // rst is still low leaves the stage at 0, so counting only
            // starts at the first edge that sees rst high.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_q[gi] <= 1'b0;
                end else begin
                    cnt_q[gi] <= cnt_d[gi];
                end
            end
        end
    endgenerate

    // Output straight from the flops: no combinational path from any input.
    assign q = cnt_q;

endmodule

// File: tb/tb_sync_up.sv
// ---------------------------------------------------------------------------
// tb_sync_up
//
// Directed bench for sync_up. It drives a WIDTH=2 instance through power-up
// reset, counting with wrap-around, a mid-count reset, a reset pulse while
// clk is held low and a reset release coincident with a rising edge. It then
// drives a WIDTH=3 instance through nine edges after reset. Expected values
// are written out by hand.
// ---------------------------------------------------------------------------
module tb_sync_up;

    logic       clk;
    logic       rst;
    logic       rst3;
    logic [1:0] q2;
    logic [2:0] q3;

    int passes;
    int total;

    sync_up #(.WIDTH(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .q   (q2)
    );

    sync_up #(.WIDTH(3)) dut3 (
        .clk (clk),
        .rst (rst3),
        .q   (q3)
    );

    // Period 10: low from 0, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    // Expected sequences after reset release.
    logic [1:0] seq_run [6] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    logic [1:0] seq_mid [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [2:0] seq_w3  [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};

    initial begin
        passes = 0;
        total  = 0;
        rst    = 1'b0;
        rst3   = 1'b0;

        // Power-up: reset low for the first 10 time units.
        #1;
        check("powerup_t1_w2", 16'(q2), 16'd0);
        check("powerup_t1_w3", 16'(q3), 16'd0);
        @(posedge clk); #1;
        check("powerup_edge_w2", 16'(q2), 16'd0);
        check("powerup_edge_w3", 16'(q3), 16'd0);

        // Release at t=10 with clk low.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("release_no_edge", 16'(q2), 16'd0);

        // Six edges: 1,2,3,0,1,2.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check($sformatf("run_edge%0d", i), 16'(q2), 16'(seq_run[i]));
        end

        // Mid-count reset with q=2, driven between edges.
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        check("midreset_async", 16'(q2), 16'd0);
        @(posedge clk); #1;
        check("midreset_hold", 16'(q2), 16'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("midreset_run%0d", i), 16'(q2), 16'(seq_mid[i]));
        end
        // q is now 0; one more edge gives 1.
        @(posedge clk); #1;
        check("pre_async", 16'(q2), 16'd1);

        // Reset pulse while clk is held low: no edge occurs in this window.
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        check("async_pulse", 16'(q2), 16'd0);
        #1;
        rst = 1'b1;
        #1;
        check("async_after_release", 16'(q2), 16'd0);
        @(posedge clk); #1;
        check("async_first_edge", 16'(q2), 16'd1);

        // Release coincident with a rising edge: that edge must not count.
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #0 rst = 1'b1;
        #1;
        check("coincident_edge", 16'(q2), 16'd0);
        @(posedge clk); #1;
        check("coincident_next", 16'(q2), 16'd1);

        // WIDTH=3 instance, held in reset until now.
        check("w3_held", 16'(q3), 16'd0);
        @(negedge clk);
        rst3 = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            check($sformatf("w3_edge%0d", i), 16'(q3), 16'(seq_w3[i]));
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/sync_up.md
SYNC_UP -- requirements
Module: sync_up

Interface
REQ-001 Parameter: WIDTH, default 2, counter width in bits (legal range 1..16).
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge only.
REQ-003 Port: rst  input  1  asynchronous, active-low reset (rst=0 resets).
REQ-004 Port: q  output  WIDTH  current count, q[0] = LSB; driven directly from state flops, no combinational path from inputs.
REQ-005 The block SHALL have exactly one clock domain (clk) and no other ports.

Function
REQ-006 The block SHALL be a synchronous binary up counter: every rising clk edge with rst=1, q <= (q + 1) mod 2^WIDTH.
REQ-007 All bits SHALL update on the same clk edge (synchronous, not ripple); no bit is clocked by another bit.
REQ-008 State SHALL be held in WIDTH JK-type flip-flop stages with J=K (toggle form); stage 0 toggles every enabled edge; stage i toggles when q[i-1:0] are all 1.
REQ-009 JK stage semantics: J=0,K=0 hold; J=0,K=1 clear; J=1,K=0 set; J=1,K=1 toggle; the counter uses only hold and toggle.
REQ-010 Wrap-around: from all-ones (3 for WIDTH=2) the next edge SHALL yield 0 with no extra cycle or stall.
REQ-011 Count sequence for WIDTH=2 SHALL be 0,1,2,3,0,1,... one step per clock.
REQ-012 Latency: q reflects an increment immediately after the rising edge that causes it (one flop delay, no pipeline).
REQ-013 No enable, load or down-count function; counting is unconditional while rst=1.

Reset
REQ-014 rst=0 SHALL force q to 0 asynchronously, independent of clk, within the same simulation time step.
REQ-015 While rst=0, q SHALL remain 0 regardless of clk activity.
REQ-016 On rst 0->1, q SHALL stay 0 until the first rising clk edge at which rst=1, which produces q=1.
REQ-017 Reset asserted mid-count (any q value) SHALL clear q to 0 immediately; counting restarts from 0 after release.
REQ-018 Reset release coincident with a rising clk edge: that edge SHALL NOT increment (q stays 0); counting begins on the next edge.
REQ-019 No X/Z SHALL appear on q after the first reset assertion.

Verification
REQ-020 Power-up: rst=0 for 10 time units with clk period 10 -> q=0 throughout.
REQ-021 Release rst, run 6 edges -> q sequence 1,2,3,0,1,2 (wrap 3->0 verified).
REQ-022 Mid-count reset: with q=2, drive rst=0 between edges -> q=0 before next clk edge, held 0 for 1 cycle; after release, next edges give 1,2,3,0.
REQ-023 Async check: pulse rst=0 while clk static low -> q=0 without any clk edge.
REQ-024 Release coincident with rising edge -> q=0 after that edge, q=1 after the following edge.
REQ-025 Parameter check: WIDTH=3, 9 edges after reset -> 1..7,0,1.
